// File: rtl/execute_stage.sv
// execute_stage: EX pipeline stage with single-cycle ALU and iterative shift-add multiplier
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   in*                 decoded operands and controls from the decode stage
//   outStall            upstream must hold its bundle (multiply in progress)
//   outValid..outBranch registered EX/MEM bundle consumed by the memory stage
module execute_stage #(
    parameter int BUS_DATA_WIDTH = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      inValid,
    input  logic                      inFlush,
    input  logic [3:0]                inAluOp,
    input  logic                      inAluSrc,
    input  logic [BUS_DATA_WIDTH-1:0] inRs1Data,
    input  logic [BUS_DATA_WIDTH-1:0] inRs2Data,
    input  logic [BUS_DATA_WIDTH-1:0] inImm,
    input  logic [BUS_DATA_WIDTH-1:0] inPc,
    input  logic [4:0]                inDestReg,
    input  logic                      inRegWrite,
    input  logic                      inMemRead,
    input  logic                      inMemWrite,
    input  logic                      inMemOrReg,
    input  logic                      inBranch,
    output logic                      outStall,
    output logic                      outValid,
    output logic [BUS_DATA_WIDTH-1:0] outResult,
    output logic [BUS_DATA_WIDTH-1:0] outWriteData,
    output logic                      outZero,
    output logic [BUS_DATA_WIDTH-1:0] outBta,
    output logic [4:0]                outDestReg,
    output logic                      outRegWrite,
    output logic                      outMemRead,
    output logic                      outMemWrite,
    output logic                      outMemOrReg,
    output logic                      outBranch
);
    localparam int W  = BUS_DATA_WIDTH;
    localparam int CW = $clog2(W);

    typedef enum logic {IDLE, MUL} stateT;

    stateT         state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  opB, aluResult, mulA, mulB, mulAcc, mulStep;
    logic [W-1:0]  lBta, lWriteData;
    logic [4:0]    lDestReg;
    logic          lRegWrite, lMemRead, lMemWrite, lMemOrReg, lBranch;
    logic          isMul, lastStep;

    assign opB      = inAluSrc ? inImm : inRs2Data;
    assign isMul    = inAluOp == 4'd10;
    assign lastStep = state == MUL && cnt == CW'(W - 1);
    assign mulStep  = mulAcc + (mulB[0] ? mulA : '0);
    // Reset gating keeps the stall low while reset is held, whatever decode presents.
    assign outStall = reset_n && !inFlush &&
                      ((state == IDLE && inValid && isMul) || (state == MUL && !lastStep));

    always_comb begin
        aluResult = '0;
        case (inAluOp)
            4'd0: aluResult = inRs1Data + opB;
            4'd1: aluResult = inRs1Data - opB;
            4'd2: aluResult = inRs1Data & opB;
            4'd3: aluResult = inRs1Data | opB;
            4'd4: aluResult = inRs1Data ^ opB;
            4'd5: aluResult = inRs1Data << opB[CW-1:0];
            4'd6: aluResult = inRs1Data >> opB[CW-1:0];
            4'd7: aluResult = $signed(inRs1Data) >>> opB[CW-1:0];
            4'd8: aluResult = {{(W-1){1'b0}}, $signed(inRs1Data) < $signed(opB)};
            4'd9: aluResult = {{(W-1){1'b0}}, inRs1Data < opB};
            default: aluResult = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            mulA         <= '0;
            mulB         <= '0;
            mulAcc       <= '0;
            lBta         <= '0;
            lWriteData   <= '0;
            lDestReg     <= '0;
            lRegWrite    <= 1'b0;
            lMemRead     <= 1'b0;
            lMemWrite    <= 1'b0;
            lMemOrReg    <= 1'b0;
            lBranch      <= 1'b0;
            outValid     <= 1'b0;
            outResult    <= '0;
            outWriteData <= '0;
            outZero      <= 1'b0;
            outBta       <= '0;
            outDestReg   <= '0;
            outRegWrite  <= 1'b0;
            outMemRead   <= 1'b0;
            outMemWrite  <= 1'b0;
            outMemOrReg  <= 1'b0;
            outBranch    <= 1'b0;
        end else begin
            // Bubble unless a branch below loads a valid bundle; data fields hold.
            outValid    <= 1'b0;
            outRegWrite <= 1'b0;
            outMemRead  <= 1'b0;
            outMemWrite <= 1'b0;
            outBranch   <= 1'b0;
            if (inFlush) begin
                state <= IDLE;
            end else if (state == MUL) begin
                mulAcc <= mulStep;
                mulA   <= mulA << 1;
                mulB   <= mulB >> 1;
                cnt    <= cnt + 1'b1;
                if (lastStep) begin
                    state        <= IDLE;
                    outValid     <= 1'b1;
                    outResult    <= mulStep;
                    outZero      <= mulStep == '0;
                    outWriteData <= lWriteData;
                    outBta       <= lBta;
                    outDestReg   <= lDestReg;
                    outRegWrite  <= lRegWrite;
                    outMemRead   <= lMemRead;
                    outMemWrite  <= lMemWrite;
                    outMemOrReg  <= lMemOrReg;
                    outBranch    <= lBranch;
                end
            end else if (inValid && isMul) begin
                state      <= MUL;
                cnt        <= '0;
                mulA       <= inRs1Data;
                mulB       <= opB;
                mulAcc     <= '0;
                lBta       <= inPc + inImm;
                lWriteData <= inRs2Data;
                lDestReg   <= inDestReg;
                lRegWrite  <= inRegWrite;
                lMemRead   <= inMemRead;
                lMemWrite  <= inMemWrite;
                lMemOrReg  <= inMemOrReg;
                lBranch    <= inBranch;
            end else if (inValid) begin
                outValid     <= 1'b1;
                outResult    <= aluResult;
                outZero      <= aluResult == '0;
                outWriteData <= inRs2Data;
                outBta       <= inPc + inImm;
                outDestReg   <= inDestReg;
                outRegWrite  <= inRegWrite;
                outMemRead   <= inMemRead;
                outMemWrite  <= inMemWrite;
                outMemOrReg  <= inMemOrReg;
                outBranch    <= inBranch;
            end
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed-vector bench for execute_stage with a cycle-level reference model
module tb_execute_stage;
    localparam int W = 64;

    logic         clk = 1'b0, reset_n = 1'b0;
    logic         inValid = 1'b0, inFlush = 1'b0, inAluSrc = 1'b0;
    logic [3:0]   inAluOp = '0;
    logic [W-1:0] inRs1Data = '0, inRs2Data = '0, inImm = '0, inPc = '0;
    logic [4:0]   inDestReg = '0;
    logic         inRegWrite = 1'b0, inMemRead = 1'b0, inMemWrite = 1'b0, inMemOrReg = 1'b0, inBranch = 1'b0;
    logic         outStall, outValid, outZero;
    logic [W-1:0] outResult, outWriteData, outBta;
    logic [4:0]   outDestReg;
    logic         outRegWrite, outMemRead, outMemWrite, outMemOrReg, outBranch;

    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    execute_stage #(.BUS_DATA_WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n), .inValid(inValid), .inFlush(inFlush),
        .inAluOp(inAluOp), .inAluSrc(inAluSrc), .inRs1Data(inRs1Data), .inRs2Data(inRs2Data),
        .inImm(inImm), .inPc(inPc), .inDestReg(inDestReg), .inRegWrite(inRegWrite),
        .inMemRead(inMemRead), .inMemWrite(inMemWrite), .inMemOrReg(inMemOrReg), .inBranch(inBranch),
        .outStall(outStall), .outValid(outValid), .outResult(outResult), .outWriteData(outWriteData),
        .outZero(outZero), .outBta(outBta), .outDestReg(outDestReg), .outRegWrite(outRegWrite),
        .outMemRead(outMemRead), .outMemWrite(outMemWrite), .outMemOrReg(outMemOrReg), .outBranch(outBranch)
    );

    // Reference model: results from plain arithmetic, the multiply as a countdown to a*b.
    logic         mValid, mZero, mRw, mMr, mMw, mMor, mBr;
    logic [W-1:0] mResult, mWd, mBta;
    logic [4:0]   mDest;
    logic [W-1:0] pResult, pWd, pBta;
    logic [4:0]   pDest;
    logic [4:0]   pCtl;
    int           busy;

    function automatic logic [W-1:0] refAlu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int sh;
        sh = int'(b[5:0]);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return $signed(a) >>> sh;
            4'd8: return ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
            4'd9: return (a < b) ? 64'd1 : 64'd0;
            default: return '0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {mValid, mZero, mRw, mMr, mMw, mMor, mBr} <= '0;
            mResult <= '0; mWd <= '0; mBta <= '0; mDest <= '0;
            busy <= 0;
        end else begin
            {mValid, mRw, mMr, mMw, mBr} <= '0;
            if (inFlush) begin
                busy <= 0;
            end else if (busy > 0) begin
                busy <= busy - 1;
                if (busy == 1) begin
                    mValid <= 1'b1; mResult <= pResult; mZero <= pResult == '0;
                    mWd <= pWd; mBta <= pBta; mDest <= pDest;
                    {mRw, mMr, mMw, mMor, mBr} <= pCtl;
                end
            end else if (inValid && inAluOp == 4'd10) begin
                busy    <= W;
                pResult <= inRs1Data * (inAluSrc ? inImm : inRs2Data);
                pWd     <= inRs2Data; pBta <= inPc + inImm; pDest <= inDestReg;
                pCtl    <= {inRegWrite, inMemRead, inMemWrite, inMemOrReg, inBranch};
            end else if (inValid) begin
                mValid  <= 1'b1;
                mResult <= refAlu(inAluOp, inRs1Data, inAluSrc ? inImm : inRs2Data);
                mZero   <= refAlu(inAluOp, inRs1Data, inAluSrc ? inImm : inRs2Data) == '0;
                mWd <= inRs2Data; mBta <= inPc + inImm; mDest <= inDestReg;
                {mRw, mMr, mMw, mMor, mBr} <= {inRegWrite, inMemRead, inMemWrite, inMemOrReg, inBranch};
            end
        end
    end

    // Every-cycle comparison of the whole DUT output bundle against the model.
    always @(negedge clk) begin
        logic expStall;
        expStall = reset_n && !inFlush && (busy > 0 ? busy > 1 : (inValid && inAluOp == 4'd10));
        checks++;
        if ({outStall, outValid, outZero, outRegWrite, outMemRead, outMemWrite, outMemOrReg, outBranch} !==
                {expStall, mValid, mZero, mRw, mMr, mMw, mMor, mBr} ||
            outResult !== mResult || outWriteData !== mWd || outBta !== mBta || outDestReg !== mDest) begin
            errors++;
            $display("FAIL cycle@%0t got stall=%b valid=%b zero=%b ctl=%b res=%h wd=%h bta=%h rd=%0d want stall=%b valid=%b zero=%b ctl=%b res=%h wd=%h bta=%h rd=%0d",
                     $time, outStall, outValid, outZero, {outRegWrite, outMemRead, outMemWrite, outMemOrReg, outBranch},
                     outResult, outWriteData, outBta, outDestReg, expStall, mValid, mZero, {mRw, mMr, mMw, mMor, mBr},
                     mResult, mWd, mBta, mDest);
        end
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] r2,
                         input logic [W-1:0] imm, input logic src, input logic [W-1:0] pc,
                         input logic [4:0] rd, input logic [4:0] ctl);
        inValid = 1'b1; inAluOp = op; inRs1Data = a; inRs2Data = r2; inImm = imm;
        inAluSrc = src; inPc = pc; inDestReg = rd;
        {inRegWrite, inMemRead, inMemWrite, inMemOrReg, inBranch} = ctl;
    endtask

    // Counts stall cycles of a held MUL, bounded; returns at the negedge where the stall drops.
    task automatic mulWait(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (outStall) n++;
            else break;
        end
    endtask

    logic [3:0]  opTab [8]  = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd9, 4'd8, 4'd12};
    logic [W-1:0] aTab [8]  = '{64'hF0F0_1234_5678_9ABC, 64'h0F0F_0000_FFFF_0001, 64'hAAAA_5555_AAAA_5555,
                                64'h0000_0000_0000_0003, 64'h8000_0000_0000_0000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd99};
    logic [W-1:0] bTab [8]  = '{64'hFF00_FF00_FF00_FF00, 64'h1000_0000_0000_0000, 64'hFFFF_0000_FFFF_0000,
                                64'd63, 64'd65, 64'd7, 64'd1, 64'd5};

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset_valid", {63'd0, outValid}, 64'd0);
        chk("reset_result", outResult, 64'd0);
        @(posedge clk); #1 reset_n = 1'b1;

        issue(4'd0, 64'd5, 64'd0, 64'd7, 1'b1, 64'h40, 5'd3, 5'b10000);
        step(); inValid = 1'b0;
        @(negedge clk);
        chk("add_result", outResult, 64'd12);
        chk("add_zero_valid_rw", {61'd0, outZero, outValid, outRegWrite}, 64'b011);

        @(posedge clk); #1;
        issue(4'd1, 64'h1234, 64'h1234, 64'h20, 1'b0, 64'h100, 5'd0, 5'b00001);
        step(); inValid = 1'b0;
        @(negedge clk);
        chk("sub_result", outResult, 64'd0);
        chk("sub_zero_branch", {62'd0, outZero, outBranch}, 64'b11);
        chk("sub_bta", outBta, 64'h120);

        @(posedge clk); #1;
        issue(4'd7, 64'h8000_0000_0000_0000, 64'd0, 64'd4, 1'b1, 64'h0, 5'd4, 5'b10000);
        step(); issue(4'd9, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'h8, 5'd5, 5'b10000);
        @(negedge clk); chk("sra", outResult, 64'hF800_0000_0000_0000);
        @(posedge clk); #1; issue(4'd8, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 64'h8, 5'd6, 5'b10000);
        @(negedge clk); chk("sltu", outResult, 64'd1);
        @(posedge clk); #1; inValid = 1'b0;
        @(negedge clk); chk("slt", outResult, 64'd0);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            issue(opTab[i], aTab[i], bTab[i], 64'(i), 1'b0, 64'(i * 4), 5'(i), 5'(i + 1));
        end
        step(); inValid = 1'b0;

        // MUL -1 * 3 with inputs held while stalled.
        issue(4'd10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h10, 1'b0, 64'h200, 5'd7, 5'b11010);
        mulWait(n);
        chk("mul_stall_cycles", 64'(n), 64'd64);
        step(); inValid = 1'b0;
        @(negedge clk);
        chk("mul_result", outResult, 64'hFFFF_FFFF_FFFF_FFFD);
        chk("mul_valid", {63'd0, outValid}, 64'd1);
        chk("mul_bta", outBta, 64'h210);

        // MUL 6*7 flushed in multiply cycle 10.
        @(posedge clk); #1;
        issue(4'd10, 64'd6, 64'd7, 64'd0, 1'b0, 64'h0, 5'd8, 5'b10000);
        repeat (11) step();
        inFlush = 1'b1;
        @(negedge clk); chk("flush_stall", {63'd0, outStall}, 64'd0);
        step(); inFlush = 1'b0; inValid = 1'b0;
        repeat (3) begin @(negedge clk); chk("flush_no_valid", {63'd0, outValid}, 64'd0); end
        @(posedge clk); #1;
        issue(4'd0, 64'd3, 64'd4, 64'd0, 1'b0, 64'h0, 5'd9, 5'b10000);
        step(); inValid = 1'b0;
        @(negedge clk); chk("post_flush_add", outResult, 64'd7);

        // Reset asserted in multiply cycle 30.
        @(posedge clk); #1;
        issue(4'd10, 64'd5, 64'd5, 64'd8, 1'b0, 64'h300, 5'd10, 5'b10000);
        repeat (31) step();
        reset_n = 1'b0;
        #1;
        chk("rst_outputs", {outStall, outValid, outZero, outRegWrite, outMemRead, outMemWrite, outMemOrReg, outBranch}, 64'd0);
        chk("rst_result", outResult | outBta | outWriteData | 64'(outDestReg), 64'd0);
        inValid = 1'b0;
        step(); step(); reset_n = 1'b1;
        @(posedge clk); #1;
        issue(4'd10, 64'd2, 64'd2, 64'd0, 1'b0, 64'h0, 5'd11, 5'b10000);
        mulWait(n);
        chk("mul2_stall_cycles", 64'(n), 64'd64);
        step(); inValid = 1'b0;
        @(negedge clk); chk("mul2_result", outResult, 64'd4);

        // Back-to-back MULs, second accepted the cycle after the first completes.
        @(posedge clk); #1;
        issue(4'd10, 64'd3, 64'd5, 64'd0, 1'b0, 64'h0, 5'd12, 5'b10000);
        mulWait(n);
        step();
        issue(4'd10, 64'd7, 64'd0, 64'd9, 1'b1, 64'h0, 5'd13, 5'b10000);
        @(negedge clk);
        chk("b2b_first", outResult, 64'd15);
        chk("b2b_accept_stall", {63'd0, outStall}, 64'd1);
        mulWait(n);
        chk("b2b_stall_cycles", 64'(n + 1), 64'd64);
        step(); inValid = 1'b0;
        @(negedge clk); chk("b2b_second", outResult, 64'd63);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- Third pipeline stage (EX): sits between decode and the data memory stage; consumes decoded operands/controls, produces the registered EX/MEM bundle the memory stage reads (result, store data, zero flag, branch target, pass-through controls).
- Single-cycle ALU ops plus an iterative 64-cycle multiplier that stalls upstream.
- Memory stage has no back-pressure, so EX emits bubbles while busy.

Parameters:
- BUS_DATA_WIDTH, 64, datapath width (multiplier iteration count equals this value).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- inValid  in  1  decode bundle valid
- inFlush  in  1  kill instruction in EX (taken branch resolved downstream)
- inAluOp  in  4  0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU,10 MUL
- inAluSrc  in  1  1: operand B = inImm, 0: operand B = inRs2Data
- inRs1Data  in  BUS_DATA_WIDTH  operand A
- inRs2Data  in  BUS_DATA_WIDTH  rs2 value / store data
- inImm  in  BUS_DATA_WIDTH  sign-extended, pre-scaled immediate
- inPc  in  BUS_DATA_WIDTH  instruction PC
- inDestReg  in  5  destination register
- inRegWrite, inMemRead, inMemWrite, inMemOrReg, inBranch  in  1 each  controls
- outStall  out  1  upstream must hold its bundle
- outValid  out  1  EX/MEM bundle valid
- outResult  out  BUS_DATA_WIDTH  ALU/MUL result
- outWriteData  out  BUS_DATA_WIDTH  registered inRs2Data
- outZero  out  1  outResult == 0
- outBta  out  BUS_DATA_WIDTH  inPc + inImm
- outDestReg  out  5; outRegWrite, outMemRead, outMemWrite, outMemOrReg, outBranch  out  1 each

Behaviour:
- Reset (async, reset_n=0): all outputs 0, FSM IDLE, multiplier counter 0. Release mid-multiply leaves no residue.
- Bubble: outValid, outRegWrite, outMemRead, outMemWrite, outBranch = 0. outResult/outZero/outBta are don't-care but keep their previous values.
- FSM has two states, IDLE and MUL.
- IDLE, inValid=1, op≠MUL, inFlush=0:
  - EX/MEM loads the computed bundle at the next edge (1-cycle latency).
  - outValid=1; controls pass through.
- Arithmetic, all modulo 2^W:
  - Shift amount is B[5:0]; SRA is arithmetic.
  - SLT is signed, SLTU unsigned; both give 0 or 1.
  - Undefined opcodes (11-15) give result 0.
- IDLE, inValid=1, op=MUL, inFlush=0 (accept cycle):
  - outStall=1 combinationally.
  - Latch A, B and all controls; counter=0; next state MUL; EX/MEM loads a bubble.
- MUL state:
  - Shift-add, one multiplier bit per cycle, counter 0..W-1. Low W bits of the product (signed and unsigned are identical).
  - outStall=1 while counter<W-1; EX/MEM loads bubbles.
  - Counter=W-1: outStall=0, EX/MEM loads the final product with the latched controls (outValid=1), next state IDLE. Upstream advances on this same edge.
  - outStall is high for exactly W consecutive cycles; the product appears W cycles after the accept edge.
- inValid=0: bubble.
- inFlush=1 (any state, priority over everything except reset):
  - outStall=0.
  - Next EX/MEM is a bubble; next state IDLE; any in-progress multiply is discarded.
- Back-to-back MULs: the second is accepted in the IDLE cycle following completion.
- outZero is derived from the registered result; outBta = inPc + inImm for every valid op (latched value for MUL).

Test Plan:
- ADD, rs1=5, imm=7, aluSrc=1 -> next cycle outResult=12, outZero=0, outValid=1, outRegWrite follows input.
- SUB, rs1=rs2=0x1234, branch=1, pc=0x100, imm=0x20 -> outResult=0, outZero=1, outBranch=1, outBta=0x120.
- MUL, rs1=0xFFFFFFFFFFFFFFFF (-1), rs2=3 -> outStall high 64 cycles, bubbles meanwhile, then outResult=0xFFFFFFFFFFFFFFFD with outValid=1.
- MUL 6x7 with inFlush pulsed in MUL cycle 10 -> outStall drops that cycle, no valid output, FSM IDLE; following ADD completes normally.
- reset_n low during MUL cycle 30 -> all outputs 0 immediately; after release, MUL 2x2 -> 4 after 64 stall cycles.
- SRA, rs1=0x8000000000000000, imm=4 -> 0xF800000000000000; SLTU(1, -1)=1; SLT(1, -1)=0.
